tt_pin_cmd_responder: RTL
=========================

Name: tt_pin_cmd_responder

Overview:
- Design-side responder for the tester-driven pin command protocol on the tile pins (ui_in / uio / uo_out).
- The bench or tester acts as initiator and runs a four-phase strobe/ack handshake to read and write a small on-chip register file.
- The block synchronizes the strobe, decodes read/write commands, drives read data onto uio, and reports ack and error status on uo_out.
- It sits directly behind the top-level tile pins and gives the bench register-level access to the design.

Parameters:
- ID_VALUE, 8'hA5, constant returned by reads of address 7.
- SYNC_STAGES, 2, flops in the strobe synchronizer. Legal values are 2..3. The test plan uses 2.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ena  in  1  tile enable, high when the design is selected.
- ui_in  in  8  command inputs:
  - [7] strobe
  - [6] rw (1 = read, 0 = write)
  - [5:3] unused
  - [2:0] addr
- uio_in  in  8  write data.
- uo_out  out  8  status:
  - [7] ack
  - [6] err
  - [5:4] always 0
  - [3] rw of the last transaction
  - [2:0] addr of the last transaction
- uio_out  out  8  read data. Equals 0 except during the ACK state of a read.
- uio_oe  out  8  8'hFF during the ACK state of a read, else 8'h00.

Behaviour:
- Reset (rst_n low, asynchronous):
  - FSM goes to IDLE; synchronizer flops clear.
  - uo_out = 0, uio_out = 0, uio_oe = 0.
  - Scratch registers 0..5 = 0; transaction counter = 0.
- Register map:
  - Addr 0..5: read/write scratch.
  - Addr 6: read-only 8-bit transaction counter.
  - Addr 7: read-only ID_VALUE.
- Strobe synchronization:
  - ui_in[7] passes through SYNC_STAGES flops; s_sync is the last flop.
  - All other ui_in bits and uio_in are sampled raw.
  - Host rule: rw, addr and data must be stable from before strobe rises until ack is seen.
- FSM states: IDLE, EXEC, ACK.
- IDLE:
  - On s_sync = 1, capture rw, addr and uio_in, then go to EXEC.
  - All outputs are 0 except uo_out[3:0], which holds the last rw/addr.
- EXEC (exactly 1 cycle):
  - Write to addr 0..5: update the register.
  - Write to addr 6 or 7: no register change; set err.
  - Read: load the addressed value into the read-data register. A read of addr 6 returns the counter value before this transaction's increment.
  - Counter increments by 1 for every EXEC, including erroring ones. It wraps 8'hFF -> 8'h00.
  - Update uo_out[3:0] to the captured rw/addr, then go to ACK.
- ACK:
  - uo_out[7] = 1 and uo_out[6] = err.
  - For a read: uio_oe = 8'hFF and uio_out = read data.
  - On s_sync = 0, go to IDLE; ack, err, uio_oe and uio_out clear on that same edge.
- Latency with SYNC_STAGES = 2:
  - Strobe first sampled high at edge k: ack is visible after edge k+3.
  - Strobe first sampled low at edge m (in ACK): ack drops after edge m+2.
- Strobe held high after ack:
  - The block stays in ACK indefinitely.
  - No new transaction starts until strobe has been seen low and then high again.
- ena low:
  - FSM forces to IDLE on the next edge; any in-flight transaction is aborted.
  - No register write occurs if abort happens before EXEC.
  - uo_out[7:4], uio_out and uio_oe are 0; registers and counter are retained.
  - The synchronizer keeps running.
- Reset mid-transaction:
  - Immediate return to reset values.
  - The host must drop strobe and restart the transaction.
- Strobe glitch shorter than 1 cycle: may be missed. If it is captured, it completes as a normal transaction.

Test Plan:
1. Reset, then check idle outputs -> uo_out = 0, uio_oe = 0, uio_out = 0; read addr 7 returns uio_out = 8'hA5 with ack.
2. Write 8'h3C to addr 2, then read addr 2:
   - Read returns 8'h3C.
   - uio_oe = 8'hFF only while ack = 1.
   - uo_out[3:0] = 4'b1010 after the read.
   - Ack rises exactly 3 edges after the strobe-high sample and falls 2 edges after the strobe-low sample.
3. Write 8'h55 to addr 7 -> ack = 1 with err = 1; a following read of addr 7 still returns 8'hA5 with err = 0.
4. Run 256 transactions, then read addr 6 -> returns 8'h00, showing counter wrap. The next read of addr 6 returns 8'h01.
5. Raise strobe for a write of 8'h77 to addr 4, and drop ena one edge after strobe is sampled high:
   - No ack.
   - Outputs are zero.
   - With ena = 1 again, a read of addr 4 returns its prior value.
6. Assert rst_n low while in ACK of a read -> uio_oe and uo_out go to 0 immediately, without waiting for a clock edge. After release, all scratch registers read 0.

Source files
------------

// File: rtl/tt_pin_cmd_responder.sv
// -----------------------------------------------------------------------------
// tt_pin_cmd_responder
//
// Responder for a tester-driven four-phase strobe/ack pin protocol. The
// initiator raises a strobe with a command (rw, addr, data) and the block
// answers with ack. The initiator then drops the strobe, and the block drops
// ack. The command gives access to a small register file:
//   addr 0..5 : read/write scratch registers
//   addr 6    : read-only transaction counter (increments once per executed
//               command, wraps at 8 bits)
//   addr 7    : read-only ID_VALUE
//
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   ena      in   tile enable; when low, any in-flight command is aborted
//   ui_in    in   [7] strobe, [6] rw (1 = read), [5:3] unused, [2:0] addr
//   uio_in   in   write data
//   uo_out   out  [7] ack, [6] err, [5:4] zero, [3] last rw, [2:0] last addr
//   uio_out  out  read data, non-zero only in the ACK state of a read
//   uio_oe   out  8'hFF in the ACK state of a read, else 8'h00
// -----------------------------------------------------------------------------
module tt_pin_cmd_responder #(
    parameter logic [7:0] ID_VALUE    = 8'hA5,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t                   state_r;
    state_t                   state_s;
    logic [SYNC_STAGES-1:0]   sync_r;
    logic                     s_sync;

    logic       cmd_rw_r;
    logic [2:0] cmd_addr_r;
    logic [7:0] cmd_data_r;
    logic       last_rw_r;
    logic [2:0] last_addr_r;
    logic       ack_r;
    logic       err_r;
    logic       rd_oe_r;
    logic [7:0] rd_data_r;
    logic [7:0] cnt_r;
    logic [7:0] scratch_r [0:5];

    logic       capture_s;
    logic       exec_s;
    logic       wr_en_s;
    logic       ack_s;
    logic       err_s;
    logic       rd_oe_s;
    logic [7:0] rd_data_s;
    logic [7:0] rd_value_s;
    logic       unused_bits_s;

    // The unused command bits are deliberately ignored.
    assign unused_bits_s = ^ui_in[5:3];

    assign s_sync  = sync_r[SYNC_STAGES-1];
    assign uo_out  = {ack_r, err_r, 2'b00, last_rw_r, last_addr_r};
    assign uio_out = rd_data_r;
    assign uio_oe  = {8{rd_oe_r}};

    // Read-data mux over the register map, using the captured address.
    // The counter is read before this transaction's own increment.
    always_comb begin
        rd_value_s = 8'h00;
        case (cmd_addr_r)
            3'd0:    rd_value_s = scratch_r[0];
            3'd1:    rd_value_s = scratch_r[1];
            3'd2:    rd_value_s = scratch_r[2];
            3'd3:    rd_value_s = scratch_r[3];
            3'd4:    rd_value_s = scratch_r[4];
            3'd5:    rd_value_s = scratch_r[5];
            3'd6:    rd_value_s = cnt_r;
            3'd7:    rd_value_s = ID_VALUE;
            default: rd_value_s = 8'h00;
        endcase
    end

    // Next-state and next-output logic for the IDLE/EXEC/ACK handshake FSM.
    always_comb begin
        state_s   = state_r;
        capture_s = 1'b0;
        exec_s    = 1'b0;
        wr_en_s   = 1'b0;
        ack_s     = ack_r;
        err_s     = err_r;
        rd_oe_s   = rd_oe_r;
        rd_data_s = rd_data_r;
        if (!ena) begin
            // Abort: nothing executes, the bus is released, and registers
            // are left untouched.
            state_s   = ST_IDLE;
            ack_s     = 1'b0;
            err_s     = 1'b0;
            rd_oe_s   = 1'b0;
            rd_data_s = 8'h00;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    ack_s     = 1'b0;
                    err_s     = 1'b0;
                    rd_oe_s   = 1'b0;
                    rd_data_s = 8'h00;
                    if (s_sync) begin
                        capture_s = 1'b1;
                        state_s   = ST_EXEC;
                    end else begin
                        state_s   = ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    exec_s    = 1'b1;
                    state_s   = ST_ACK;
                    ack_s     = 1'b1;
                    err_s     = !cmd_rw_r && (cmd_addr_r >= 3'd6);
                    wr_en_s   = !cmd_rw_r && (cmd_addr_r < 3'd6);
                    rd_oe_s   = cmd_rw_r;
                    rd_data_s = cmd_rw_r ? rd_value_s : 8'h00;
                end
                ST_ACK: begin
                    // Staying here while strobe is high means a new command
                    // needs a fresh low-then-high strobe.
                    if (!s_sync) begin
                        state_s   = ST_IDLE;
                        ack_s     = 1'b0;
                        err_s     = 1'b0;
                        rd_oe_s   = 1'b0;
                        rd_data_s = 8'h00;
                    end else begin
                        state_s   = ST_ACK;
                    end
                end
                default: begin
                    state_s   = ST_IDLE;
                    ack_s     = 1'b0;
                    err_s     = 1'b0;
                    rd_oe_s   = 1'b0;
                    rd_data_s = 8'h00;
                end
            endcase
        end
    end

    // State, strobe synchronizer, command capture, register file and outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            sync_r      <= '0;
            cmd_rw_r    <= 1'b0;
            cmd_addr_r  <= 3'd0;
            cmd_data_r  <= 8'h00;
            last_rw_r   <= 1'b0;
            last_addr_r <= 3'd0;
            ack_r       <= 1'b0;
            err_r       <= 1'b0;
            rd_oe_r     <= 1'b0;
            rd_data_r   <= 8'h00;
            cnt_r       <= 8'h00;
            for (int i = 0; i < 6; i++) begin
                scratch_r[i] <= 8'h00;
            end
        end else begin
            sync_r  <= {sync_r[SYNC_STAGES-2:0], ui_in[7]};
            state_r <= state_s;
            if (capture_s) begin
                cmd_rw_r   <= ui_in[6];
                cmd_addr_r <= ui_in[2:0];
                cmd_data_r <= uio_in;
            end
            if (exec_s) begin
                cnt_r       <= cnt_r + 8'd1;
                last_rw_r   <= cmd_rw_r;
                last_addr_r <= cmd_addr_r;
            end
            for (int i = 0; i < 6; i++) begin
                if (wr_en_s && (cmd_addr_r == 3'(i))) begin
                    scratch_r[i] <= cmd_data_r;
                end
            end
            ack_r     <= ack_s;
            err_r     <= err_s;
            rd_oe_r   <= rd_oe_s;
            rd_data_r <= rd_data_s;
        end
    end

endmodule
